power_unit: RTL and testbench

Parametrised sequential power unit computing P = X^A by LSB-first square-and-multiply. It is the next-generation replacement for the fixed 4-bit exponent block. It adds configurable operand/result widths, an overflow flag and a busy indication, and takes one cycle per exponent bit per step instead of repeated multiplication. It sits behind the AXI4-Lite register front-end as the compute core.

---
 rtl/power_pkg.sv | 17 +
 rtl/power_mul.sv | 23 ++
 rtl/power_unit.sv | 152 +++++++++++++++
 tb/tb_power_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/power_pkg.sv
// power_pkg: shared definitions for the power_unit compute core.
//   - power_state_t : 2-bit FSM state encoding (S_IDLE, S_MUL, S_SQR, S_DONE)
//   - XW_DEF/AW_DEF/PW_DEF : default base, exponent and result widths
package power_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SQR  = 2'd2,
    S_DONE = 2'd3
  } power_state_t;

  localparam int XW_DEF = 8;
  localparam int AW_DEF = 8;
  localparam int PW_DEF = 32;

endpackage

// File: rtl/power_mul.sv
// power_mul: combinational PW x PW multiplier.
// Ports:
//   a, b : PW-bit operands
//   lo   : low PW bits of a*b
//   ovf  : high when the upper PW bits of the full product are nonzero
module power_mul
  import power_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [PW-1:0] lo,
  output logic          ovf
);

  logic [2*PW-1:0] prod;

  assign prod = {{PW{1'b0}}, a} * {{PW{1'b0}}, b};
  assign lo   = prod[PW-1:0];
  assign ovf  = |prod[2*PW-1:PW];

endmodule

// File: rtl/power_unit.sv
// power_unit: sequential P = X^A using LSB-first square-and-multiply.
// One exponent bit costs two cycles (MUL then SQR); a single shared
// power_mul instance serves both steps through an operand mux.
//
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_load  : latch i_X/i_A into the operand registers (IDLE only)
//   i_start : begin a computation (IDLE only)
//   i_X     : base, XW bits
//   i_A     : exponent, AW bits
//   o_busy  : high while in MUL or SQR
//   o_done  : one-cycle completion pulse (the DONE state)
//   o_ovf   : true result did not fit in PW bits; valid with o_done, held after
//   o_P     : result, held until the next completion
//   o_state : current FSM state, for debug/checkers
//
// Control semantics: i_load and i_start are level-sampled strobes, acted on
// only on a rising edge where the FSM is in IDLE; in any other state they are
// dropped (no queuing). When both are high together, the start uses i_X/i_A
// directly, otherwise it uses the previously latched operands.
//
// Build option: define POWER_SAT_EN to saturate o_P to all-ones when the
// result overflows; without it o_P is the true result mod 2^PW.
// PW must be >= XW.
module power_unit
  import power_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_start,
  input  logic [XW-1:0] i_X,
  input  logic [AW-1:0] i_A,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ovf,
  output logic [PW-1:0] o_P,
  output power_state_t  o_state
);

  power_state_t  state;
  logic [XW-1:0] r_x;
  logic [AW-1:0] r_a;
  logic [PW-1:0] acc;
  logic [PW-1:0] base;
  logic [AW-1:0] e;
  logic          ovf;
  logic          base_ovf;

  logic [XW-1:0] x_sel;
  logic [AW-1:0] a_sel;
  logic [PW-1:0] mul_a;
  logic [PW-1:0] mul_lo;
  logic          mul_ovf;
  logic [PW-1:0] result;

  // Same-cycle load+start bypasses the operand registers.
  assign x_sel = i_load ? i_X : r_x;
  assign a_sel = i_load ? i_A : r_a;

  // MUL computes acc*base, SQR computes base*base.
  assign mul_a = (state == S_SQR) ? base : acc;

  power_mul #(.PW(PW)) u_mul (
    .a   (mul_a),
    .b   (base),
    .lo  (mul_lo),
    .ovf (mul_ovf)
  );

`ifdef POWER_SAT_EN
  assign result = ovf ? {PW{1'b1}} : acc;
`else
  assign result = acc;
`endif

  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      r_x      <= '0;
      r_a      <= '0;
      acc      <= '0;
      base     <= '0;
      e        <= '0;
      ovf      <= 1'b0;
      base_ovf <= 1'b0;
      o_P      <= '0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_load) begin
            r_x <= i_X;
            r_a <= i_A;
          end
          if (i_start) begin
            acc      <= PW'(1);
            base     <= PW'(x_sel);
            e        <= a_sel;
            ovf      <= 1'b0;
            base_ovf <= 1'b0;
            o_ovf    <= 1'b0;
            o_busy   <= 1'b1;
            state    <= S_MUL;
          end
        end
        S_MUL: begin
          if (e == '0) begin
            o_P    <= result;
            o_ovf  <= ovf;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_DONE;
          end else begin
            // An already-overflowed base makes the true product overflow too.
            if (e[0]) begin
              acc <= mul_lo;
              ovf <= ovf | mul_ovf | base_ovf;
            end
            state <= S_SQR;
          end
        end
        S_SQR: begin
          e <= e >> 1;
          // Skip the last square: it is never used and could flag a false
          // overflow.
          if ((e >> 1) != '0) begin
            base     <= mul_lo;
            base_ovf <= base_ovf | mul_ovf;
          end
          state <= S_MUL;
        end
        S_DONE: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_power_unit.sv
// tb_power_unit: self-checking bench for power_unit (default widths 8/8/32).
// Expected results come from a repeated-multiplication reference model; the
// expected cycle timing comes from the bit length of the exponent.
module tb_power_unit;
  import power_pkg::*;

  localparam int XW = 8;
  localparam int AW = 8;
  localparam int PW = 32;

  logic          clk;
  logic          i_rst;
  logic          i_load;
  logic          i_start;
  logic [XW-1:0] i_X;
  logic [AW-1:0] i_A;
  logic          o_busy;
  logic          o_done;
  logic          o_ovf;
  logic [PW-1:0] o_P;
  power_state_t  o_state;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] exp_q[$];
  logic          ovf_q[$];

  // Bench copy of the operand registers, updated only on accepted loads.
  logic [XW-1:0] m_rx = '0;
  logic [AW-1:0] m_ra = '0;

  power_unit #(.XW(XW), .AW(AW), .PW(PW)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_load  (i_load),
    .i_start (i_start),
    .i_X     (i_X),
    .i_A     (i_A),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_ovf   (o_ovf),
    .o_P     (o_P),
    .o_state (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic [XW-1:0] x, input logic [AW-1:0] a,
                                output logic [PW-1:0] p, output logic ov);
    logic [2*PW-1:0] t;
    p  = PW'(1);
    ov = 1'b0;
    for (int i = 0; i < int'(a); i++) begin
      t = (2*PW)'(p) * (2*PW)'(x);
      if (t[2*PW-1:PW] != '0) ov = 1'b1;
      p = t[PW-1:0];
    end
`ifdef POWER_SAT_EN
    if (ov) p = '1;
`endif
  endfunction

  function automatic int bit_len(input logic [AW-1:0] a);
    int l;
    l = 0;
    for (int i = 0; i < AW; i++) if (a[i]) l = i + 1;
    return l;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    m_rx = '0;
    m_ra = '0;
  endtask

  // mode 0: load cycle then start; mode 1: same-cycle load+start;
  // mode 2: start only (latched operands). pulse: strobe start/load mid-run
  // and in the done cycle. abort_k >= 0: assert reset k cycles after start.
  task automatic do_op(input logic [XW-1:0] x, input logic [AW-1:0] a,
                       input int mode, input bit pulse, input int abort_k);
    logic [XW-1:0] ex;
    logic [AW-1:0] ea;
    logic [PW-1:0] ep;
    logic          eo;
    logic [PW-1:0] held_p;
    int            l;
    int            busy_n;
    bit            seen;
    if (mode == 0) begin
      i_load = 1'b1; i_X = x; i_A = a;
      @(negedge clk);
      i_load = 1'b0;
      m_rx = x; m_ra = a;
    end else if (mode == 1) begin
      i_load = 1'b1; i_X = x; i_A = a;
      m_rx = x; m_ra = a;
    end else begin
      i_X = XW'($urandom); i_A = AW'($urandom);
    end
    ex = m_rx; ea = m_ra;
    model(ex, ea, ep, eo);
    exp_q.push_back(ep);
    ovf_q.push_back(eo);
    l = bit_len(ea);
    i_start = 1'b1;
    seen = 1'b0;
    busy_n = 0;
    for (int k = 0; k <= 2*AW + 4; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_load  = 1'b0;
      if (abort_k == k) begin
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        void'(exp_q.pop_back());
        void'(ovf_q.pop_back());
        m_rx = '0; m_ra = '0;
        check("abort_busy", 64'(o_busy), 64'(0));
        check("abort_done", 64'(o_done), 64'(0));
        check("abort_ovf", 64'(o_ovf), 64'(0));
        check("abort_p", 64'(o_P), 64'(0));
        check("abort_state", 64'(o_state), 64'(S_IDLE));
        for (int j = 0; j < 2*l + 4; j++) begin
          @(negedge clk);
          check("abort_no_done", 64'(o_done), 64'(0));
        end
        return;
      end
      if (pulse && k == 3) begin
        i_start = 1'b1; i_load = 1'b1;
        i_X = ~ex; i_A = ea + AW'(1);
      end
      check("busy", 64'(o_busy), 64'(k <= 2*l));
      check("done_timing", 64'(o_done), 64'(k == 2*l + 1));
      if (o_busy) busy_n++;
      if (o_done) begin
        check("result_p", 64'(o_P), 64'(exp_q.pop_front()));
        check("result_ovf", 64'(o_ovf), 64'(ovf_q.pop_front()));
        check("busy_cycles", 64'(busy_n), 64'(2*l + 1));
        held_p = o_P;
        seen = 1'b1;
        if (pulse) i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("idle_busy", 64'(o_busy), 64'(0));
        check("done_single", 64'(o_done), 64'(0));
        check("p_held", 64'(o_P), 64'(held_p));
        break;
      end
    end
    if (!seen) check("timeout_no_done", 64'(0), 64'(1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    i_rst = 1'b0; i_load = 1'b0; i_start = 1'b0; i_X = '0; i_A = '0;
    @(negedge clk);
    apply_reset();
    check("rst_p", 64'(o_P), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_ovf", 64'(o_ovf), 64'(0));
    check("rst_state", 64'(o_state), 64'(S_IDLE));

    do_op(8'd9, 8'd9, 0, 1'b0, -1);     // 387420489
    do_op(8'd3, 8'd0, 1, 1'b0, -1);     // 1
    do_op(8'd0, 8'd0, 1, 1'b0, -1);     // 0^0 = 1
    do_op(8'd0, 8'd5, 0, 1'b0, -1);     // 0
    do_op(8'd2, 8'd31, 1, 1'b0, -1);    // 2^31
    do_op(8'd2, 8'd32, 1, 1'b0, -1);    // overflow
    do_op(8'd255, 8'd4, 0, 1'b0, -1);   // fits, no false overflow
    do_op(8'd255, 8'd5, 1, 1'b0, -1);   // overflow
    do_op(8'd2, 8'd3, 1, 1'b1, -1);     // 8, with ignored strobes
    do_op(8'd0, 8'd0, 2, 1'b0, -1);     // reuses latched 2,3 -> 8
    do_op(8'd9, 8'd9, 0, 1'b0, 1);      // reset during SQR
    do_op(8'd9, 8'd9, 2, 1'b0, -1);     // latched operands now 0,0 -> 1
    do_op(8'd7, 8'd11, 0, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      logic [XW-1:0] rx;
      logic [AW-1:0] ra;
      rx = XW'($urandom_range(0, 255));
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255))
                                       : AW'($urandom_range(0, 40));
      do_op(rx, ra, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
